// File: rtl/jpeg_chroma_pkg.sv
// ----------------------------------------------------------------------------
// jpeg_chroma_pkg
// Shared definitions for the JPEG front-end chroma subsampler.
//   - chroma_mode_e : subsampling mode encoding (444 / 422 / 420; 3 acts as 420)
//   - CHROMA_DATA_W : default chroma sample width
// No ports (package).
// ----------------------------------------------------------------------------
package jpeg_chroma_pkg;

    localparam int CHROMA_DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_444 = 2'd0,
        MODE_422 = 2'd1,
        MODE_420 = 2'd2,
        MODE_RSV = 2'd3
    } chroma_mode_e;

endpackage : jpeg_chroma_pkg

// File: rtl/chroma_line_buf.sv
// ----------------------------------------------------------------------------
// chroma_line_buf
// Half-line buffer holding the horizontal Cb/Cr pair sums of an even row so
// the following odd row can complete the 2x2 average. One write port, one
// combinational read port. Contents are intentionally not reset; every entry
// is rewritten by the next even row before it is read.
//
// Ports:
//   clk        in   clock
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write address (pair index, col >> 1)
//   i_wr_data  in   packed {cb_sum, cr_sum}
//   i_rd_addr  in   read address (pair index, col >> 1)
//   o_rd_data  out  packed {cb_sum, cr_sum}, combinational
// ----------------------------------------------------------------------------
module chroma_line_buf #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int WORD_W = 18
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : chroma_line_buf

// File: rtl/chroma_subsampler.sv
// ----------------------------------------------------------------------------
// chroma_subsampler
// Raster-order Cb/Cr stream subsampler: 4:4:4 passthrough, 4:2:2 horizontal
// pair average, or 4:2:0 2x2 block average using a half-line buffer of pair
// sums. Mode is latched on each accepted frame_start beat.
//
// Build option (macro CHROMA_ROUND_EN):
//   defined   : round-half-up (+1 before >>1, +2 before >>2)
//   undefined : truncation, bit-compatible with the legacy shift averager
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   mode[1:0]    in   0=444, 1=422, 2=420, 3=420; sampled on frame_start beat
//   frame_start  in   current beat is row 0, col 0
//   in_valid     in   input beat valid
//   in_ready     out  block can accept a beat
//   cb_in/cr_in  in   chroma samples
//   out_valid    out  output pair valid
//   out_ready    in   downstream accepts
//   cb_out/cr_out out subsampled chroma
// ----------------------------------------------------------------------------
module chroma_subsampler
    import jpeg_chroma_pkg::*;
#(
    parameter int DATA_W = CHROMA_DATA_W,
    parameter int IMG_W  = 16,
    parameter int COL_W  = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              frame_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] cb_in,
    input  logic [DATA_W-1:0] cr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] cb_out,
    output logic [DATA_W-1:0] cr_out
);

    localparam int SUM_W   = DATA_W + 1;
    localparam int QUAD_W  = DATA_W + 2;
    localparam int ADDR_W  = (COL_W > 1) ? COL_W - 1 : 1;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

`ifdef CHROMA_ROUND_EN
    localparam logic [SUM_W-1:0]  RND2 = SUM_W'(1);
    localparam logic [QUAD_W-1:0] RND4 = QUAD_W'(2);
`else
    localparam logic [SUM_W-1:0]  RND2 = '0;
    localparam logic [QUAD_W-1:0] RND4 = '0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COL_W-1:0]  r_col;
    logic              r_row_odd;
    chroma_mode_e      r_mode_q;
    logic [DATA_W-1:0] r_cb_left;
    logic [DATA_W-1:0] r_cr_left;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_cb_out;
    logic [DATA_W-1:0] r_cr_out;

    // ------------------------------------------------------------------
    // Beat position: a frame_start beat is forced to row 0 / col 0 and
    // uses the incoming mode, so a mid-line restart needs no extra cycle.
    // ------------------------------------------------------------------
    logic              w_accept;
    logic [COL_W-1:0]  w_col;
    logic              w_row_odd;
    chroma_mode_e      w_mode;
    logic              w_col_odd;
    logic              w_col_wrap;
    logic              w_is_420;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_col      = frame_start ? '0   : r_col;
    assign w_row_odd  = frame_start ? 1'b0 : r_row_odd;
    assign w_mode     = frame_start ? chroma_mode_e'(mode) : r_mode_q;
    assign w_col_odd  = w_col[0];
    assign w_col_wrap = (w_col == COL_LAST);
    assign w_is_420   = (w_mode == MODE_420) || (w_mode == MODE_RSV);

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]    w_cb_sum2;
    logic [SUM_W-1:0]    w_cr_sum2;
    logic [SUM_W-1:0]    w_cb_rnd2;
    logic [SUM_W-1:0]    w_cr_rnd2;
    logic [QUAD_W-1:0]   w_cb_quad;
    logic [QUAD_W-1:0]   w_cr_quad;
    logic [2*SUM_W-1:0]  w_lb_rd_data;
    logic [SUM_W-1:0]    w_cb_stored;
    logic [SUM_W-1:0]    w_cr_stored;

    assign w_cb_sum2 = {1'b0, r_cb_left} + {1'b0, cb_in};
    assign w_cr_sum2 = {1'b0, r_cr_left} + {1'b0, cr_in};

    // 2*max + 1 still fits in DATA_W+1 bits
    assign w_cb_rnd2 = w_cb_sum2 + RND2;
    assign w_cr_rnd2 = w_cr_sum2 + RND2;

    assign w_cb_stored = w_lb_rd_data[2*SUM_W-1:SUM_W];
    assign w_cr_stored = w_lb_rd_data[SUM_W-1:0];

    // 4*max + 2 still fits in DATA_W+2 bits
    assign w_cb_quad = {1'b0, w_cb_stored} + {1'b0, w_cb_sum2} + RND4;
    assign w_cr_quad = {1'b0, w_cr_stored} + {1'b0, w_cr_sum2} + RND4;

    // ------------------------------------------------------------------
    // Line buffer: even rows of 420 write pair sums, odd rows read them
    // back at the same pair index.
    // ------------------------------------------------------------------
    logic              w_lb_wr_en;
    logic [ADDR_W-1:0] w_lb_addr;

    assign w_lb_wr_en = w_accept && w_is_420 && w_col_odd && !w_row_odd;

    generate
        if (COL_W > 1) begin : g_addr_wide
            assign w_lb_addr = w_col[COL_W-1:1];
        end else begin : g_addr_one
            assign w_lb_addr = '0;
        end
    endgenerate

    chroma_line_buf #(
        .DEPTH  (LB_DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (2 * SUM_W)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_lb_wr_en),
        .i_wr_addr (w_lb_addr),
        .i_wr_data ({w_cb_sum2, w_cr_sum2}),
        .i_rd_addr (w_lb_addr),
        .o_rd_data (w_lb_rd_data)
    );

    // ------------------------------------------------------------------
    // Result select for the current beat
    // ------------------------------------------------------------------
    logic              w_result;
    logic [DATA_W-1:0] w_cb_res;
    logic [DATA_W-1:0] w_cr_res;

    always_comb begin
        w_result = 1'b0;
        w_cb_res = cb_in;
        w_cr_res = cr_in;
        case (w_mode)
            MODE_444: begin
                w_result = 1'b1;
            end
            MODE_422: begin
                if (w_col_odd) begin
                    w_result = 1'b1;
                    w_cb_res = w_cb_rnd2[SUM_W-1:1];
                    w_cr_res = w_cr_rnd2[SUM_W-1:1];
                end
            end
            default: begin
                if (w_col_odd && w_row_odd) begin
                    w_result = 1'b1;
                    w_cb_res = w_cb_quad[QUAD_W-1:2];
                    w_cr_res = w_cr_quad[QUAD_W-1:2];
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Position, mode and left-pixel registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row_odd <= 1'b0;
            r_mode_q  <= MODE_444;
            r_cb_left <= '0;
            r_cr_left <= '0;
        end else if (w_accept) begin
            r_col     <= w_col_wrap ? '0 : w_col + COL_W'(1);
            r_row_odd <= w_col_wrap ? ~w_row_odd : w_row_odd;
            if (frame_start) begin
                r_mode_q <= chroma_mode_e'(mode);
            end
            if (!w_col_odd) begin
                r_cb_left <= cb_in;
                r_cr_left <= cr_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: loads on a completing beat (possibly in the same
    // cycle the previous result is taken), otherwise drains on out_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_cb_out    <= '0;
            r_cr_out    <= '0;
        end else if (w_accept && w_result) begin
            r_out_valid <= 1'b1;
            r_cb_out    <= w_cb_res;
            r_cr_out    <= w_cr_res;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign cb_out    = r_cb_out;
    assign cr_out    = r_cr_out;

endmodule : chroma_subsampler
